// File: rtl/clock_display_serializer.sv
// Serializes a four-digit 7-segment time display frame (MSB first) to an
// external shift-register display, then strobes latch and pulses done.
module clock_display_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hours_msd,
  input  logic [3:0] hours_lsd,
  input  logic [3:0] minutes_msd,
  input  logic [3:0] minutes_lsd,
  input  logic       pm,
  input  logic       colon,
  input  logic       blank_zero,
  output logic       sclk,
  output logic       sdata,
  output logic       latch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        phase_q, phase_d;
  logic        sclk_d, sdata_d, latch_d, busy_d, done_d;
  logic        sclk_q, sdata_q, latch_q, busy_q, done_q;

  // BCD digit to {g,f,e,d,c,b,a}; non-BCD values show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // State, frame/counter and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: capture on start in IDLE, two cycles per bit, one latch cycle.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d[31:24] = (blank_zero && (hours_msd == 4'd0)) ? 8'h00
                                                               : {1'b0, seg7(hours_msd)};
          frame_d[23:16] = {colon, seg7(hours_lsd)};
          frame_d[15:8]  = {1'b0, seg7(minutes_msd)};
          frame_d[7:0]   = {pm, seg7(minutes_lsd)};
          bit_cnt_d      = 5'd31;
          phase_d        = 1'b0;
          state_d        = SHIFT;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (bit_cnt_q == 5'd0) begin
          phase_d = 1'b0;
          state_d = LATCH;
        end else begin
          phase_d   = 1'b0;
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe rather than trailing it by a cycle.
  always_comb begin
    sclk_d  = (state_d == SHIFT) && phase_d;
    sdata_d = (state_d == SHIFT) ? frame_d[bit_cnt_d] : 1'b0;
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == LATCH) && (state_d == IDLE);
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign latch = latch_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_clock_display_serializer.sv
// Directed bench for clock_display_serializer.
module tb_clock_display_serializer;

  logic       clk = 1'b0;
  logic       reset, start, pm, colon, blank_zero;
  logic [3:0] hours_msd, hours_lsd, minutes_msd, minutes_lsd;
  logic       sclk, sdata, latch, busy, done;

  int tests  = 0;
  int failed = 0;

  clock_display_serializer dut (
    .clk(clk), .reset(reset), .start(start),
    .hours_msd(hours_msd), .hours_lsd(hours_lsd),
    .minutes_msd(minutes_msd), .minutes_lsd(minutes_lsd),
    .pm(pm), .colon(colon), .blank_zero(blank_zero),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] hm, input logic [3:0] hl, input logic [3:0] mm,
                        input logic [3:0] ml, input logic p, input logic c, input logic b);
    hours_msd = hm; hours_lsd = hl; minutes_msd = mm; minutes_lsd = ml;
    pm = p; colon = c; blank_zero = b;
  endtask

  // Called at a negedge; sends one frame and checks bits, timing and strobes.
  // change_at >= 0 rewrites the inputs mid-SHIFT to the alternate time 08:76.
  task automatic do_frame(input logic [31:0] exp, input string tag,
                          input bit keep_start, input int change_at);
    logic [31:0] got = '0;
    int   bits = 0, busy_cyc = 0, latch_cnt = 0, sd_err = 0;
    logic prev_sclk = 1'b0, prev_sdata = 1'b0;
    bit   done_seen = 0;
    start = 1'b1;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    check({tag, "_first_busy"}, {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == change_at) set_in(4'd0, 4'd8, 4'd7, 4'd6, 1'b1, 1'b0, 1'b0);
      if (done) begin
        done_seen = 1;
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        break;
      end
      if (busy) busy_cyc++;
      if (sclk && !prev_sclk) begin
        got = {got[30:0], sdata};
        bits++;
        if (sdata !== prev_sdata) sd_err++;
      end
      if (latch) begin
        latch_cnt++;
        check({tag, "_latch_bits"}, bits, 32'd32);
        check({tag, "_latch_lines"}, {30'd0, sclk, sdata}, 32'd0);
      end
      prev_sclk  = sclk;
      prev_sdata = sdata;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    check({tag, "_frame"}, got, exp);
    check({tag, "_busy_cycles"}, busy_cyc, 32'd65);
    check({tag, "_latch_count"}, latch_cnt, 32'd1);
    check({tag, "_sdata_stable"}, sd_err, 32'd0);
  endtask

  initial begin
    int lat, dn, bz;
    reset = 1'b1; start = 1'b0;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, sclk, sdata, latch, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", {27'd0, sclk, sdata, latch, busy, done}, 32'd0);

    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1);
    do_frame(32'h06DB4FE6, "f12_34", 0, -1);
    set_in(4'd0, 4'd9, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    do_frame(32'h006F3F6D, "blank_on", 0, -1);
    blank_zero = 1'b0;
    do_frame(32'h3F6F3F6D, "blank_off", 0, -1);
    set_in(4'd0, 4'hC, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    do_frame(32'h3F403F3F, "dash", 0, -1);

    // Start held high: first frame unaffected by mid-SHIFT input change,
    // second frame (accepted in the done cycle) carries the new inputs.
    set_in(4'd1, 4'd2, 4'd5, 4'd9, 1'b0, 1'b1, 1'b0);
    do_frame(32'h06DB6D6F, "b2b_a", 1, 20);
    do_frame(32'h3F7F07FD, "b2b_b", 0, -1);

    // Reset at bit 16 (with start also high) aborts the frame.
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_outputs", {27'd0, sclk, sdata, latch, busy, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    lat = 0; dn = 0; bz = 0;
    for (int i = 0; i < 70; i++) begin
      if (latch) lat++;
      if (done) dn++;
      if (busy) bz++;
      @(negedge clk);
    end
    check("abort_no_latch", lat, 32'd0);
    check("abort_no_done", dn, 32'd0);
    check("abort_no_busy", bz, 32'd0);
    do_frame(32'h06DB4FE6, "after_abort", 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
